// File: rtl/neocore_pkg.sv
// Shared NeoCore pipeline-control types: sequencer state encoding and perf counter helpers.
package neocore_pkg;

  typedef enum logic [1:0] {
    PS_RUN    = 2'd0,
    PS_DRAIN  = 2'd1,
    PS_HALTED = 2'd2
  } pipe_state_t;

  localparam int unsigned PERF_CNT_W = 32;

  // Saturating increment: a pinned counter stays at all-ones rather than wrapping.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v,
                                                   input logic                  en);
    logic [PERF_CNT_W-1:0] r;
    r = v;
    if (en && (v != '1)) begin
      r = v + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard comparator: ID source registers against both EX destinations.
module pipe_hazard_detect
  import neocore_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [3:0] ex_rd_addr,
  input  logic [3:0] ex_rd2_addr,
  input  logic       ex_rd_we,
  input  logic       ex_rd2_we,
  input  logic       id_valid,
  input  logic [3:0] id_rs1_addr,
  input  logic [3:0] id_rs2_addr,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       load_use
);

  logic src1_hit;
  logic src2_hit;

  always_comb begin
    src1_hit = (ex_rd_we  && (id_rs1_addr == ex_rd_addr)) ||
               (ex_rd2_we && (id_rs1_addr == ex_rd2_addr));
    src2_hit = (ex_rd_we  && (id_rs2_addr == ex_rd_addr)) ||
               (ex_rd2_we && (id_rs2_addr == ex_rd2_addr));
    load_use = ex_valid && ex_mem_read && id_valid &&
               ((id_uses_rs1 && src1_hit) || (id_uses_rs2 && src2_hit));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// NeoCore stall/flush sequencer with HALT drain and data-memory watchdog.
// Optional performance counters are built when NEOCORE_PIPE_PERF_EN is defined.
module pipeline_ctrl
  import neocore_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic                  id_valid,
  input  logic [3:0]            id_rs1_addr,
  input  logic [3:0]            id_rs2_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_is_halt,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [3:0]            ex_rd_addr,
  input  logic [3:0]            ex_rd2_addr,
  input  logic                  ex_rd_we,
  input  logic                  ex_rd2_we,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  wb_valid,
  input  logic                  wb_is_halt,
  output logic                  pc_stall,
  output logic                  pc_redirect,
  output logic                  stall_if_id,
  output logic                  stall_id_ex,
  output logic                  stall_ex_mem,
  output logic                  stall_mem_wb,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic                  flush_mem_wb,
  output logic                  halted,
  output logic                  mem_error,
  output logic [PERF_CNT_W-1:0] perf_stall_cycles,
  output logic [PERF_CNT_W-1:0] perf_flush_count,
  output logic [PERF_CNT_W-1:0] perf_retired
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  pipe_state_t       state_q, state_d;
  pipe_state_t       eff_state;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_error_q, mem_error_d;

  logic mem_wait;
  logic branch;
  logic load_use;
  logic wd_fire;

  pipe_hazard_detect u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd_addr  (ex_rd_addr),
    .ex_rd2_addr (ex_rd2_addr),
    .ex_rd_we    (ex_rd_we),
    .ex_rd2_we   (ex_rd2_we),
    .id_valid    (id_valid),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .load_use    (load_use)
  );

  always_comb begin
    mem_wait = mem_req && !mem_ready;
    branch   = ex_valid && ex_branch_taken;
    wd_fire  = (MEM_TIMEOUT != 0) && mem_wait && (wait_cnt_q == WAIT_LAST);
  end

  // Control outputs; while rst is high the sequencer presents as RUN.
  always_comb begin
    pc_stall     = 1'b0;
    pc_redirect  = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    eff_state    = rst ? PS_RUN : state_q;

    case (eff_state)
      PS_HALTED: begin
        pc_stall     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        stall_mem_wb = 1'b1;
      end
      default: begin
        if (mem_wait) begin
          pc_stall     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          stall_ex_mem = 1'b1;
          flush_mem_wb = 1'b1;
        end else if (branch) begin
          pc_redirect = (eff_state == PS_RUN);
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (!fetch_valid && (eff_state == PS_RUN)) begin
          pc_stall    = 1'b1;
          flush_if_id = 1'b1;
        end
        // Draining keeps IF/ID empty; the flush wins over a load-use hold there.
        if ((eff_state == PS_DRAIN) && !mem_wait) begin
          pc_stall    = 1'b1;
          flush_if_id = 1'b1;
          stall_if_id = 1'b0;
        end
      end
    endcase

    halted    = (eff_state == PS_HALTED);
    mem_error = mem_error_q && !rst;
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = mem_wait ? (wait_cnt_q + 1'b1) : '0;
    mem_error_d = mem_error_q || wd_fire;

    unique case (state_q)
      PS_RUN: begin
        if (id_valid && id_is_halt && !mem_wait && !branch && !load_use) begin
          state_d = PS_DRAIN;
        end
      end
      PS_DRAIN: begin
        if (wb_valid && wb_is_halt) begin
          state_d = PS_HALTED;
        end
      end
      default: state_d = PS_HALTED;
    endcase

    if (wd_fire) begin
      state_d = PS_HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PS_RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

`ifdef NEOCORE_PIPE_PERF_EN
  logic [PERF_CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_CNT_W-1:0] perf_flush_q, perf_flush_d;
  logic [PERF_CNT_W-1:0] perf_ret_q,   perf_ret_d;
  logic                  count_en;
  logic                  any_flush;

  always_comb begin
    count_en     = (state_q != PS_HALTED);
    any_flush    = flush_if_id || flush_id_ex || flush_ex_mem || flush_mem_wb;
    perf_stall_d = sat_inc(perf_stall_q, count_en && pc_stall);
    perf_flush_d = sat_inc(perf_flush_q, count_en && any_flush);
    perf_ret_d   = sat_inc(perf_ret_q,   count_en && wb_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_ret_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_ret_q   <= perf_ret_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
  assign perf_retired      = perf_ret_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_count  = '0;
  assign perf_retired      = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: behavioural model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_pipeline_ctrl;
  import neocore_pkg::*;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic fetch_valid, id_valid, id_uses_rs1, id_uses_rs2, id_is_halt;
  logic [3:0] id_rs1_addr, id_rs2_addr, ex_rd_addr, ex_rd2_addr;
  logic ex_valid, ex_mem_read, ex_rd_we, ex_rd2_we, ex_branch_taken;
  logic mem_req, mem_ready, wb_valid, wb_is_halt;
  logic pc_stall, pc_redirect;
  logic stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic halted, mem_error;
  logic [31:0] perf_stall_cycles, perf_flush_count, perf_retired;

  pipeline_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_halt(id_is_halt),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_rd2_addr(ex_rd2_addr), .ex_rd_we(ex_rd_we), .ex_rd2_we(ex_rd2_we),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_valid(wb_valid), .wb_is_halt(wb_is_halt), .pc_stall(pc_stall),
    .pc_redirect(pc_redirect), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
    .halted(halted), .mem_error(mem_error), .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_count(perf_flush_count), .perf_retired(perf_retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  // {pc_stall, pc_redirect, stalls if/id/ex/wb, flushes if/id/ex/wb, halted, mem_error}
  typedef struct packed {
    logic       pc_stall;
    logic       pc_redirect;
    logic [3:0] st;
    logic [3:0] fl;
    logic       halted;
    logic       mem_error;
  } ctrl_t;

  bit          m_halted, m_drain, m_err;
  int unsigned m_wait_run;
  longint unsigned m_stall, m_flush, m_ret;

  function automatic bit hits(input logic [3:0] a);
    return (ex_rd_we && a == ex_rd_addr) || (ex_rd2_we && a == ex_rd2_addr);
  endfunction

  function automatic bit m_lu();
    return ex_valid && ex_mem_read && id_valid &&
           ((id_uses_rs1 && hits(id_rs1_addr)) || (id_uses_rs2 && hits(id_rs2_addr)));
  endfunction

  function automatic ctrl_t model_ctrl();
    ctrl_t e;
    bit wt, br, lu, hn, dn;
    e  = '0;
    wt = mem_req && !mem_ready;
    br = ex_valid && ex_branch_taken;
    lu = m_lu();
    hn = m_halted && !rst;
    dn = m_drain && !rst;
    if (hn) begin
      e.pc_stall = 1'b1; e.st = 4'b1111; e.halted = 1'b1;
    end else if (wt) begin
      e.pc_stall = 1'b1; e.st = 4'b1110; e.fl = 4'b0001;
    end else begin
      if (br) begin
        e.pc_redirect = !dn; e.fl = 4'b1100;
      end else if (lu) begin
        e.pc_stall = 1'b1; e.st = 4'b1000; e.fl = 4'b0100;
      end else if (!fetch_valid && !dn) begin
        e.pc_stall = 1'b1; e.fl = 4'b1000;
      end
      if (dn) begin
        e.pc_stall = 1'b1; e.fl[3] = 1'b1; e.st[3] = 1'b0;
      end
    end
    e.mem_error = m_err && !rst;
    return e;
  endfunction

  function automatic ctrl_t ctrl_now();
    return {pc_stall, pc_redirect, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
            flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, halted, mem_error};
  endfunction

  function automatic longint unsigned sat(input longint unsigned v);
    return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
  endfunction

  function automatic logic [31:0] perf_exp(input longint unsigned v);
`ifdef NEOCORE_PIPE_PERF_EN
    return v[31:0];
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  always @(posedge clk) begin
    ctrl_t e;
    bit wt, br, lu, fire;
    e  = model_ctrl();
    wt = mem_req && !mem_ready;
    br = ex_valid && ex_branch_taken;
    lu = m_lu();
    if (rst) begin
      m_halted = 0; m_drain = 0; m_err = 0; m_wait_run = 0;
      m_stall = 0; m_flush = 0; m_ret = 0;
    end else begin
      if (!m_halted) begin
        if (e.pc_stall) m_stall = sat(m_stall);
        if (e.fl != 0)  m_flush = sat(m_flush);
        if (wb_valid)   m_ret   = sat(m_ret);
      end
      fire = (TO > 0) && wt && (m_wait_run == TO - 1);
      m_wait_run = wt ? m_wait_run + 1 : 0;
      if (fire) begin
        m_err = 1; m_halted = 1; m_drain = 0;
      end else if (m_drain && wb_valid && wb_is_halt) begin
        m_halted = 1; m_drain = 0;
      end else if (!m_halted && !m_drain && id_valid && id_is_halt && !wt && !br && !lu) begin
        m_drain = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      ctrl_t e, g;
      e = model_ctrl();
      g = ctrl_now();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL ctrl t=%0t got=%b exp=%b", $time, g, e);
      end
      checks++;
      if (perf_stall_cycles !== perf_exp(m_stall)) begin
        errors++;
        $display("FAIL perf_stall t=%0t got=%0d exp=%0d", $time, perf_stall_cycles, perf_exp(m_stall));
      end
      checks++;
      if (perf_flush_count !== perf_exp(m_flush)) begin
        errors++;
        $display("FAIL perf_flush t=%0t got=%0d exp=%0d", $time, perf_flush_count, perf_exp(m_flush));
      end
      checks++;
      if (perf_retired !== perf_exp(m_ret)) begin
        errors++;
        $display("FAIL perf_retired t=%0t got=%0d exp=%0d", $time, perf_retired, perf_exp(m_ret));
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic idle();
    fetch_valid = 1; id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_is_halt = 0;
    ex_valid = 0; ex_mem_read = 0; ex_rd_addr = 0; ex_rd2_addr = 0;
    ex_rd_we = 0; ex_rd2_we = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0; wb_valid = 0; wb_is_halt = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu();
    ex_valid = 1; ex_mem_read = 1; ex_rd_addr = 3; ex_rd_we = 1;
    id_valid = 1; id_rs1_addr = 3; id_uses_rs1 = 1;
  endtask

  localparam logic [12:0] C_LU    = 13'b1_0_1000_0100_0_0;
  localparam logic [12:0] C_BR    = 13'b0_1_0000_1100_0_0;
  localparam logic [12:0] C_WAIT  = 13'b1_0_1110_0001_0_0;
  localparam logic [12:0] C_STARV = 13'b1_0_0000_1000_0_0;
  localparam logic [12:0] C_HALT  = 13'b1_0_1111_0000_1_0;
  localparam logic [12:0] C_WDOG  = 13'b1_0_1111_0000_1_1;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; idle(); fetch_valid = 0;
    cyc();
    run_cmp = 1;
    #1 lit("reset_starve", ctrl_now(), C_STARV);

    cyc(); rst = 0; fetch_valid = 1;
    #1 lit("idle_run", ctrl_now(), 0);

    cyc(); set_lu();
    #1 lit("load_use_rs1", ctrl_now(), C_LU);
    cyc(); ex_valid = 0; mem_req = 1; mem_ready = 1;
    #1 lit("after_load_use", ctrl_now(), 0);

    cyc(); idle(); ex_valid = 1; ex_mem_read = 1; ex_rd_addr = 7; ex_rd_we = 1;
    ex_rd2_addr = 5; ex_rd2_we = 1; id_valid = 1; id_rs1_addr = 2; id_uses_rs1 = 1;
    id_rs2_addr = 5; id_uses_rs2 = 1;
    #1 lit("load_use_rs2_rd2", ctrl_now(), C_LU);
    cyc(); id_uses_rs2 = 0;
    #1 lit("src_not_used", ctrl_now(), 0);
    cyc(); id_uses_rs2 = 1; ex_rd2_we = 0;
    #1 lit("rd2_we_off", ctrl_now(), 0);

    cyc(); idle(); set_lu(); ex_branch_taken = 1;
    #1 lit("branch_over_lu", ctrl_now(), C_BR);

    cyc(); idle(); ex_valid = 1; ex_branch_taken = 1; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 lit("wait_holds_branch", ctrl_now(), C_WAIT);
      cyc();
    end
    mem_ready = 1;
    #1 lit("branch_after_wait", ctrl_now(), C_BR);

    cyc(); idle(); mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      lit("wait_cnt_cleared", {31'd0, halted}, 0);
    end
    mem_ready = 1;
    cyc(); idle(); fetch_valid = 0;
    #1 lit("fetch_starve", ctrl_now(), C_STARV);

    cyc(); idle(); id_valid = 1; id_is_halt = 1;
    #1 lit("halt_in_id", ctrl_now(), 0);
    cyc(); idle(); ex_valid = 1;
    #1 lit("drain_1", ctrl_now(), C_STARV);
    cyc(); idle(); mem_req = 1;
    #1 lit("drain_wait", ctrl_now(), C_WAIT);
    cyc(); idle(); wb_valid = 1; wb_is_halt = 1;
    #1 lit("drain_wb_halt", ctrl_now(), C_STARV);
    cyc(); idle(); ex_valid = 1; ex_branch_taken = 1; fetch_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1 lit("halted_sticky", ctrl_now(), C_HALT);
      cyc();
    end

    rst = 1; idle();
    #1 lit("rst_from_halt", {31'd0, halted}, 0);
    cyc(); rst = 0;
    #1 lit("run_after_rst", ctrl_now(), 0);

    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1 lit("wdog_waiting", ctrl_now(), C_WAIT);
      cyc();
    end
    #1 lit("wdog_fired", ctrl_now(), C_WDOG);
    cyc();
    rst = 1;
    #1 lit("rst_clears_err", {30'd0, halted, mem_error}, 0);
    cyc(); rst = 0; idle();
    #1 lit("err_cleared", ctrl_now(), 0);

    rst = 1;
    cyc(); rst = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i == 2 || i == 5) set_lu();
      if (i == 7) begin ex_valid = 1; ex_branch_taken = 1; end
      if (i != 5 && i != 7 && i != 9) wb_valid = 1;
      cyc();
    end
`ifdef NEOCORE_PIPE_PERF_EN
    lit("perf_stall_lit", perf_stall_cycles, 2);
    lit("perf_flush_lit", perf_flush_count, 3);
    lit("perf_retired_lit", perf_retired, 7);
`else
    lit("perf_stall_tied", perf_stall_cycles, 0);
    lit("perf_flush_tied", perf_flush_count, 0);
    lit("perf_retired_tied", perf_retired, 0);
`endif
    idle();
    cyc();
    cyc();
    run_cmp = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
